// File: rtl/serial_tx_framer_pkg.sv
// Shared definitions for the serial transmit framer: parity modes, FSM states
// and the parity-bit helper.
package serial_tx_framer_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity transmits the XOR of the data bits; odd parity transmits its inverse.
  function automatic logic parity_bit(input logic acc, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/serial_tx_framer_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Free-running bit counter, held at zero while restart is asserted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/serial_tx_framer.sv
// Parametrised asynchronous serial transmitter: start, LSB-first data,
// optional parity, 1 or 2 stop bits, each bit CLKS_PER_BIT clocks long.
module serial_tx_framer
  import serial_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 2,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 D,
  output logic                 Busy
);

  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  if ((DATA_BITS < 5) || (DATA_BITS > 16) || (PARITY_MODE > 2) ||
      (STOP_BITS < 1) || (STOP_BITS > 2) || (CLKS_PER_BIT < 1)) begin : g_bad_param
    $error("serial_tx_framer: illegal parameter combination");
  end

  tx_state_e            r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_par, w_par;
  logic [BW-1:0]        r_bit_idx, w_bit_idx;
  logic [SW-1:0]        r_stop_idx, w_stop_idx;
  logic                 r_d, w_d;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_accept;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .restart (r_state == ST_IDLE),
    .bit_end (w_bit_end)
  );

  assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_stop_idx == SW'(STOP_BITS - 1));
  assign Ready       = (r_state == ST_IDLE) || w_last_stop;
  assign w_accept    = Valid && Ready;
  assign Busy        = (r_state != ST_IDLE);
  assign D           = r_d;

  // Next-state logic; D is computed one clock ahead so the line is registered.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_par      = r_par;
    w_bit_idx  = r_bit_idx;
    w_stop_idx = r_stop_idx;
    w_d        = r_d;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state = ST_START;
          w_shift = Din;
          w_par   = 1'b0;
          w_d     = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state   = ST_DATA;
          w_bit_idx = '0;
          w_d       = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_par   = r_par ^ r_shift[0];
          w_shift = r_shift >> 1;
          if (r_bit_idx == BW'(DATA_BITS - 1)) begin
            if (PARITY_MODE != PARITY_NONE) begin
              w_state = ST_PARITY;
              w_d     = parity_bit(w_par, PARITY_MODE);
            end else begin
              w_state    = ST_STOP;
              w_stop_idx = '0;
              w_d        = 1'b1;
            end
          end else begin
            w_bit_idx = r_bit_idx + BW'(1);
            w_d       = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state    = ST_STOP;
          w_stop_idx = '0;
          w_d        = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_last_stop) begin
          if (w_accept) begin
            w_state = ST_START;
            w_shift = Din;
            w_par   = 1'b0;
            w_d     = 1'b0;
          end else begin
            w_state = ST_IDLE;
            w_d     = 1'b1;
          end
        end else if (w_bit_end) begin
          w_stop_idx = r_stop_idx + SW'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_d     = 1'b1;
      end
    endcase
  end

  // State, datapath and line registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
      r_d        <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_par      <= w_par;
      r_bit_idx  <= w_bit_idx;
      r_stop_idx <= w_stop_idx;
      r_d        <= w_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three configurations driven from shared stimulus,
// each checked every cycle against a frame-level model.
module tb_serial_tx_framer;

  localparam int NI = 3;
  localparam int DBV [NI] = '{8, 8, 5};
  localparam int PMV [NI] = '{1, 2, 0};
  localparam int SBV [NI] = '{1, 2, 2};
  localparam int CPV [NI] = '{4, 3, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] din;
  logic        d_w    [NI];
  logic        busy_w [NI];
  logic        rdy_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_tx_framer #(
      .DATA_BITS    (DBV[g]),
      .PARITY_MODE  (PMV[g]),
      .STOP_BITS    (SBV[g]),
      .CLKS_PER_BIT (CPV[g])
    ) u_dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .Din   (din[DBV[g]-1:0]),
      .Valid (valid),
      .Ready (rdy_w[g]),
      .D     (d_w[g]),
      .Busy  (busy_w[g])
    );
  end

  // Model: per instance, the serial bits of the current frame and the clock
  // position within it (-1 when idle).
  int          pos   [NI];
  logic [31:0] fbits [NI];
  int          n_vec;
  int          n_bad;

  function automatic int flen(input int i);
    return 1 + DBV[i] + ((PMV[i] != 0) ? 1 : 0) + SBV[i];
  endfunction

  function automatic logic [31:0] frame_bits(input int i, input logic [15:0] w);
    logic [31:0] b;
    logic p;
    b = '1;
    p = 1'b0;
    b[0] = 1'b0;
    for (int j = 0; j < DBV[i]; j++) begin
      b[1 + j] = w[j];
      p = p ^ w[j];
    end
    if (PMV[i] != 0) b[1 + DBV[i]] = (PMV[i] == 2) ? ~p : p;
    return b;
  endfunction

  function automatic logic exp_ready(input int i);
    return (pos[i] < 0) || (pos[i] == flen(i) * CPV[i] - 1);
  endfunction

  function automatic logic exp_d(input int i);
    if (pos[i] < 0) return 1'b1;
    return fbits[i][pos[i] / CPV[i]];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        pos[i] = -1;
      end else begin
        logic acc;
        acc = valid && exp_ready(i);
        if (pos[i] >= 0) begin
          pos[i] = pos[i] + 1;
          if (pos[i] == flen(i) * CPV[i]) pos[i] = -1;
        end
        if (acc) begin
          fbits[i] = frame_bits(i, din);
          pos[i]   = 0;
        end
      end
    end
  endtask

  task automatic check(input string nm, input int i, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check("D", i, d_w[i], exp_d(i));
      check("Busy", i, busy_w[i], pos[i] >= 0);
      check("Ready", i, rdy_w[i], exp_ready(i));
    end
  endtask

  // One clock: model sees the edge with the inputs in force, new inputs are
  // driven shortly after, and outputs are compared on the falling edge.
  task automatic step(input logic v, input logic [15:0] w);
    @(posedge clk);
    model_edge();
    #2;
    valid = v;
    din   = w;
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) pos[i] = -1;
  endtask

  // Sends one word and samples instance 0 at the middle of each bit; Din and
  // Valid are scrambled mid-frame while instance 0 cannot accept.
  task automatic run_frame0(input logic [15:0] w, input logic [10:0] exp, input string nm);
    logic [10:0] got;
    got = '0;
    step(1'b1, w);
    for (int k = 0; k < 48; k++) begin
      step((k >= 1 && k <= 30) ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
      if ((k % 4 == 1) && (k / 4 < 11)) got[k / 4] = d_w[0];
      if (k == 42) check("frame_ready_early", 0, rdy_w[0], 1'b0);
      if (k == 43) check("frame_ready_last", 0, rdy_w[0], 1'b1);
      if (k == 44) check("frame_busy_after", 0, busy_w[0], 1'b0);
    end
    check_vec(nm, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0] got8;
    n_vec = 0;
    n_bad = 0;
    valid = 1'b0;
    din   = '0;
    reset_now();
    repeat (3) step(1'b0, 16'h0000);
    rst_n = 1'b1;

    // 8'hA5, even parity: 0,1,0,1,0,0,1,0,1,0,1
    run_frame0(16'h00A5, 11'b10101001010, "frame_A5");

    // Parity of 8'h07 (XOR = 1): even -> 1, odd -> 0
    step(1'b1, 16'h0007);
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 16'($urandom));
      if (k == 37) check("par_even_07", 0, d_w[0], 1'b1);
      if (k == 28) check("par_odd_07", 1, d_w[1], 1'b0);
    end

    // 5 bits, no parity, 2 stops, 1 clock per bit
    got8 = '0;
    step(1'b1, 16'h001F);
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 16'($urandom));
      if (k < 8) got8[k] = d_w[2];
      if (k == 7) check("short_ready_last", 2, rdy_w[2], 1'b1);
      if (k == 8) check("short_busy_after", 2, busy_w[2], 1'b0);
    end
    check_vec("frame_1F", 32'(got8), 32'(8'b11111110));

    // Back-to-back: Valid held, 8'h55 then 8'hAA
    step(1'b1, 16'h0055);
    for (int k = 0; k < 100; k++) begin
      step(k < 44, 16'h00AA);
      if (k == 42) check("b2b_ready_early", 0, rdy_w[0], 1'b0);
      if (k == 43) check("b2b_ready_pulse", 0, rdy_w[0], 1'b1);
      if (k == 44) check("b2b_start_bit", 0, d_w[0], 1'b0);
      if (k == 44) check("b2b_busy_cont", 0, busy_w[0], 1'b1);
    end

    // Reset during data bit 3 of instance 0
    step(1'b1, 16'h00A5);
    for (int k = 0; k < 18; k++) step(1'b0, 16'($urandom));
    #1;
    reset_now();
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_D", i, d_w[i], 1'b1);
      check("rst_Busy", i, busy_w[i], 1'b0);
    end
    repeat (2) step(1'b0, 16'h0000);
    rst_n = 1'b1;
    // 8'h3C, even parity: 0,0,0,1,1,1,1,0,0,0,1
    run_frame0(16'h003C, 11'b10001111000, "frame_3C");

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 2) == 0, 16'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        #1;
        reset_now();
        step(1'b0, 16'($urandom));
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
